// File: rtl/jt10_adpcma_ctrl_pkg.sv
// Shared constants and helpers for the ADPCM-A CPU register controller.
// Register bases are the channel-0 addresses; channels 0..5 follow contiguously.
package jt10_adpcma_ctrl_pkg;

  localparam int CH_N = 6;

  localparam logic [7:0] ADPCMA_KEY = 8'h00;
  localparam logic [7:0] START_L    = 8'h10;
  localparam logic [7:0] START_H    = 8'h18;
  localparam logic [7:0] END_L      = 8'h20;
  localparam logic [7:0] END_H      = 8'h28;

  // Returns {valid, index}; valid only when exactly one bit is set.
  function automatic logic [3:0] onehot_to_idx(input logic [5:0] oh);
    logic [2:0] idx;
    int unsigned cnt;
    idx = 3'd0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
        cnt = cnt + 1;
      end
    end
    return {(cnt == 1), idx};
  endfunction

endpackage

// File: rtl/jt10_adpcma_pend.sv
// Per-channel request holder: key-on/off and start/end address requests
// plus the address shadows. A write on the same edge as service wins.
module jt10_adpcma_pend
  import jt10_adpcma_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        svc,
  input  logic        key_on,
  input  logic        key_off,
  input  logic        wr_lo_s,
  input  logic        wr_hi_s,
  input  logic        wr_lo_e,
  input  logic        wr_hi_e,
  input  logic [7:0]  din,
  output logic        pon,
  output logic        poff,
  output logic        pstart,
  output logic        pend,
  output logic        en,
  output logic [15:0] start_addr,
  output logic [15:0] end_addr
);

  logic        pon_q, pon_d;
  logic        poff_q, poff_d;
  logic        pstart_q, pstart_d;
  logic        pend_q, pend_d;
  logic        en_q, en_d;
  logic [7:0]  lo_s_q, lo_s_d;
  logic [7:0]  lo_e_q, lo_e_d;
  logic [15:0] start_q, start_d;
  logic [15:0] end_q, end_d;

  always_comb begin
    pon_d    = pon_q;
    poff_d   = poff_q;
    pstart_d = pstart_q;
    pend_d   = pend_q;
    en_d     = en_q;
    lo_s_d   = lo_s_q;
    lo_e_d   = lo_e_q;
    start_d  = start_q;
    end_d    = end_q;

    if (svc) begin
      if (pon_q)  en_d = 1'b1;
      if (poff_q) en_d = 1'b0;
      pon_d  = 1'b0;
      poff_d = 1'b0;
      // Only one address update per slot; start goes first.
      if (pstart_q) pstart_d = 1'b0;
      else          pend_d   = 1'b0;
    end

    if (key_on) begin
      pon_d  = 1'b1;
      poff_d = 1'b0;
    end
    if (key_off) begin
      poff_d = 1'b1;
      pon_d  = 1'b0;
    end

    if (wr_lo_s) lo_s_d = din;
    if (wr_lo_e) lo_e_d = din;
    if (wr_hi_s) begin
      start_d  = {din, lo_s_q};
      pstart_d = 1'b1;
    end
    if (wr_hi_e) begin
      end_d  = {din, lo_e_q};
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pon_q    <= 1'b0;
      poff_q   <= 1'b0;
      pstart_q <= 1'b0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      lo_s_q   <= 8'd0;
      lo_e_q   <= 8'd0;
      start_q  <= 16'd0;
      end_q    <= 16'd0;
    end else begin
      pon_q    <= pon_d;
      poff_q   <= poff_d;
      pstart_q <= pstart_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      lo_s_q   <= lo_s_d;
      lo_e_q   <= lo_e_d;
      start_q  <= start_d;
      end_q    <= end_d;
    end
  end

  assign pon        = pon_q;
  assign poff       = poff_q;
  assign pstart     = pstart_q;
  assign pend       = pend_q;
  assign en         = en_q;
  assign start_addr = start_q;
  assign end_addr   = end_q;

endmodule

// File: rtl/jt10_adpcma_ctrl.sv
// ADPCM-A CPU register controller: decodes writes into per-channel requests
// and issues them as pulses aligned to each channel's counter slot.
module jt10_adpcma_ctrl
  import jt10_adpcma_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [5:0]  cur_ch,
  input  logic        wr,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  output logic        aon,
  output logic        aoff,
  output logic [15:0] addr_in,
  output logic [2:0]  addr_ch,
  output logic        up_start,
  output logic        up_end,
  output logic [5:0]  en_ch,
  output logic        busy
);

  logic [CH_N-1:0] pon, poff, pstart, pend, svc_vec;
  logic [CH_N-1:0] key_on_vec, key_off_vec;
  logic [15:0]     start_arr [CH_N];
  logic [15:0]     end_arr   [CH_N];
  logic [3:0]      oh_res;
  logic            oh_valid;
  logic            is_key;
  logic            ch_ok;
  logic [2:0]      wch;
  logic [4:0]      blk;

  assign oh_res   = onehot_to_idx(cur_ch);
  assign oh_valid = oh_res[3];
  assign svc_vec  = (cen && oh_valid) ? cur_ch : '0;

  assign is_key      = wr && (addr == ADPCMA_KEY);
  assign key_on_vec  = (is_key && !din[7]) ? din[5:0] : '0;
  assign key_off_vec = (is_key &&  din[7]) ? din[5:0] : '0;

  // Channel field is the low 3 bits; 6 and 7 fall through as no-ops.
  assign wch   = addr[2:0];
  assign blk   = addr[7:3];
  assign ch_ok = wr && (wch < 3'd6);

  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    logic sel;
    assign sel = ch_ok && (wch == 3'(c));

    jt10_adpcma_pend u_pend (
      .clk        (clk),
      .rst        (rst),
      .svc        (svc_vec[c]),
      .key_on     (key_on_vec[c]),
      .key_off    (key_off_vec[c]),
      .wr_lo_s    (sel && (blk == START_L[7:3])),
      .wr_hi_s    (sel && (blk == START_H[7:3])),
      .wr_lo_e    (sel && (blk == END_L[7:3])),
      .wr_hi_e    (sel && (blk == END_H[7:3])),
      .din        (din),
      .pon        (pon[c]),
      .poff       (poff[c]),
      .pstart     (pstart[c]),
      .pend       (pend[c]),
      .en         (en_ch[c]),
      .start_addr (start_arr[c]),
      .end_addr   (end_arr[c])
    );
  end

  assign aon  = |(pon  & svc_vec);
  assign aoff = |(poff & svc_vec);
  assign busy = |(pon | poff | pstart | pend);

  always_comb begin
    up_start = 1'b0;
    up_end   = 1'b0;
    addr_in  = 16'd0;
    addr_ch  = 3'd0;
    for (int i = 0; i < CH_N; i++) begin
      if (svc_vec[i]) begin
        if (pstart[i]) begin
          up_start = 1'b1;
          addr_in  = start_arr[i];
          addr_ch  = 3'(i);
        end else if (pend[i]) begin
          up_end  = 1'b1;
          addr_in = end_arr[i];
          addr_ch = 3'(i);
        end
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcma_ctrl.sv
// Self-checking bench for jt10_adpcma_ctrl: table vectors, directed corner
// sequences and random traffic against an array-based request model.
module tb_jt10_adpcma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [5:0]  cur_ch;
  logic        wr;
  logic [7:0]  addr;
  logic [7:0]  din;
  logic        aon, aoff, up_start, up_end, busy;
  logic [15:0] addr_in;
  logic [2:0]  addr_ch;
  logic [5:0]  en_ch;

  jt10_adpcma_ctrl dut (
    .clk(clk), .rst(rst), .cen(cen), .cur_ch(cur_ch), .wr(wr), .addr(addr), .din(din),
    .aon(aon), .aoff(aoff), .addr_in(addr_in), .addr_ch(addr_ch),
    .up_start(up_start), .up_end(up_end), .en_ch(en_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit m_pon [6];
  bit m_poff[6];
  bit m_ps  [6];
  bit m_pe  [6];
  bit m_en  [6];
  int m_start[6];
  int m_end  [6];
  int m_los  [6];
  int m_loe  [6];

  typedef struct {
    bit          cen;
    logic [5:0]  cur;
    bit          wr;
    logic [7:0]  a;
    logic [7:0]  d;
    bit          aon;
    bit          aoff;
    bit          us;
    bit          ue;
    logic [15:0] ain;
    logic [2:0]  ach;
    logic [5:0]  en;
    bit          busy;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_pon[i] = 0; m_poff[i] = 0; m_ps[i] = 0; m_pe[i] = 0; m_en[i] = 0;
      m_start[i] = 0; m_end[i] = 0; m_los[i] = 0; m_loe[i] = 0;
    end
  endtask

  // Which channel (if any) is being served this cycle.
  task automatic slot(output bit svc, output int k);
    int n;
    n = 0;
    k = 0;
    for (int i = 0; i < 6; i++) if (cur_ch[i]) begin n++; k = i; end
    svc = cen && (n == 1);
  endtask

  task automatic check_model(input string tag);
    bit svc;
    int k;
    bit e_aon, e_aoff, e_us, e_ue;
    int e_ain, e_ach, e_en, e_busy;
    slot(svc, k);
    e_aon  = svc && m_pon[k];
    e_aoff = svc && m_poff[k];
    e_us   = svc && m_ps[k];
    e_ue   = svc && !m_ps[k] && m_pe[k];
    e_ain  = e_us ? m_start[k] : (e_ue ? m_end[k] : 0);
    e_ach  = (e_us || e_ue) ? k : 0;
    e_en   = 0;
    e_busy = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_en[i]) e_en += (1 << i);
      if (m_pon[i] || m_poff[i] || m_ps[i] || m_pe[i]) e_busy = 1;
    end
    chk({tag, ".aon"},      int'(aon),      int'(e_aon));
    chk({tag, ".aoff"},     int'(aoff),     int'(e_aoff));
    chk({tag, ".up_start"}, int'(up_start), int'(e_us));
    chk({tag, ".up_end"},   int'(up_end),   int'(e_ue));
    chk({tag, ".addr_in"},  int'(addr_in),  e_ain);
    chk({tag, ".addr_ch"},  int'(addr_ch),  e_ach);
    chk({tag, ".en_ch"},    int'(en_ch),    e_en);
    chk({tag, ".busy"},     int'(busy),     e_busy);
  endtask

  task automatic model_step();
    bit svc;
    int k, c, base;
    slot(svc, k);
    if (svc) begin
      if (m_pon[k])  m_en[k] = 1;
      if (m_poff[k]) m_en[k] = 0;
      m_pon[k]  = 0;
      m_poff[k] = 0;
      if (m_ps[k]) m_ps[k] = 0;
      else         m_pe[k] = 0;
    end
    if (wr) begin
      if (addr == 8'h00) begin
        for (int i = 0; i < 6; i++) if (din[i]) begin
          m_pon[i]  = !din[7];
          m_poff[i] = din[7];
        end
      end else begin
        c    = int'(addr) % 8;
        base = int'(addr) - c;
        if (c < 6) begin
          case (base)
            'h10: m_los[c] = int'(din);
            'h18: begin m_start[c] = int'(din) * 256 + m_los[c]; m_ps[c] = 1; end
            'h20: m_loe[c] = int'(din);
            'h28: begin m_end[c] = int'(din) * 256 + m_loe[c]; m_pe[c] = 1; end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic drive(input bit c, input logic [5:0] cc, input bit w,
                       input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cen = c; cur_ch = cc; wr = w; addr = a; din = d;
    #1;
    check_model("model");
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic rot(input int k);
    drive(1'b1, 6'(1 << k), 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  function automatic vec_t mk(bit c, logic [5:0] cc, bit w, logic [7:0] a, logic [7:0] d,
                              bit e_aon, bit e_aoff, bit e_us, bit e_ue, logic [15:0] e_ain,
                              logic [2:0] e_ach, logic [5:0] e_en, bit e_busy);
    vec_t v;
    v.cen = c; v.cur = cc; v.wr = w; v.a = a; v.d = d;
    v.aon = e_aon; v.aoff = e_aoff; v.us = e_us; v.ue = e_ue;
    v.ain = e_ain; v.ach = e_ach; v.en = e_en; v.busy = e_busy;
    return v;
  endfunction

  initial begin
    // Key-on of channels 0 and 2, then one full rotation.
    tbl[0]  = mk(0, 6'b000000, 1, 8'h00, 8'h05, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000000, 0);
    tbl[1]  = mk(1, 6'b000001, 0, 8'h00, 8'h00, 1, 0, 0, 0, 16'h0000, 3'd0, 6'b000000, 1);
    tbl[2]  = mk(1, 6'b000010, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000001, 1);
    tbl[3]  = mk(1, 6'b000100, 0, 8'h00, 8'h00, 1, 0, 0, 0, 16'h0000, 3'd0, 6'b000001, 1);
    tbl[4]  = mk(1, 6'b001000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 0);
    tbl[5]  = mk(1, 6'b010000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 0);
    tbl[6]  = mk(1, 6'b100000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 0);
    // Channel 3 start/end, start first, end one rotation later.
    tbl[7]  = mk(0, 6'b000000, 1, 8'h13, 8'h40, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 0);
    tbl[8]  = mk(0, 6'b000000, 1, 8'h1B, 8'h12, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 0);
    tbl[9]  = mk(0, 6'b000000, 1, 8'h23, 8'hFF, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 1);
    tbl[10] = mk(0, 6'b001000, 1, 8'h2B, 8'h13, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 1);
    tbl[11] = mk(1, 6'b001000, 0, 8'h00, 8'h00, 0, 0, 1, 0, 16'h1240, 3'd3, 6'b000101, 1);
    tbl[12] = mk(1, 6'b010000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 1);
    tbl[13] = mk(1, 6'b100000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 1);
    tbl[14] = mk(1, 6'b000001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 1);
    tbl[15] = mk(1, 6'b000010, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 1);
    tbl[16] = mk(1, 6'b000100, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 1);
    tbl[17] = mk(1, 6'b001000, 0, 8'h00, 8'h00, 0, 0, 0, 1, 16'h13FF, 3'd3, 6'b000101, 1);
    tbl[18] = mk(0, 6'b000000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3'd0, 6'b000101, 0);

    rst = 1'b1; cen = 1'b1; cur_ch = 6'b000001; wr = 1'b0; addr = 8'h00; din = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.aon", int'(aon), 0);
    chk("reset.up_start", int'(up_start), 0);
    chk("reset.addr_in", int'(addr_in), 0);
    chk("reset.en_ch", int'(en_ch), 0);
    chk("reset.busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].cen, tbl[i].cur, tbl[i].wr, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d.aon", i),      int'(aon),      int'(tbl[i].aon));
      chk($sformatf("tbl%0d.aoff", i),     int'(aoff),     int'(tbl[i].aoff));
      chk($sformatf("tbl%0d.up_start", i), int'(up_start), int'(tbl[i].us));
      chk($sformatf("tbl%0d.up_end", i),   int'(up_end),   int'(tbl[i].ue));
      chk($sformatf("tbl%0d.addr_in", i),  int'(addr_in),  int'(tbl[i].ain));
      chk($sformatf("tbl%0d.addr_ch", i),  int'(addr_ch),  int'(tbl[i].ach));
      chk($sformatf("tbl%0d.en_ch", i),    int'(en_ch),    int'(tbl[i].en));
      chk($sformatf("tbl%0d.busy", i),     int'(busy),     int'(tbl[i].busy));
      tick();
    end

    // Key ch1 on, then on/off override before its slot: off wins.
    drive(0, 6'b000000, 1, 8'h00, 8'h02); tick();
    rot(1);
    #1 chk("ovr.pre_en1", int'(en_ch[1]), 1);
    drive(0, 6'b000000, 1, 8'h00, 8'h02); tick();
    drive(0, 6'b000000, 1, 8'h00, 8'h82); tick();
    drive(1, 6'b000010, 0, 8'h00, 8'h00);
    chk("ovr.aoff", int'(aoff), 1);
    chk("ovr.aon", int'(aon), 0);
    tick();
    #1 chk("ovr.en1", int'(en_ch[1]), 0);

    // Write collides with service of the same key-on bit: stays pending.
    drive(0, 6'b000000, 1, 8'h00, 8'h01); tick();
    drive(1, 6'b000001, 1, 8'h00, 8'h01);
    chk("coll.aon1", int'(aon), 1);
    tick();
    #1 chk("coll.busy_mid", int'(busy), 1);
    for (int k = 1; k < 6; k++) rot(k);
    drive(1, 6'b000001, 0, 8'h00, 8'h00);
    chk("coll.aon2", int'(aon), 1);
    tick();
    #1 chk("coll.en0", int'(en_ch[0]), 1);
    chk("coll.busy_end", int'(busy), 0);

    // Channel 6/7 and unmapped addresses change nothing.
    drive(0, 6'b000000, 1, 8'h16, 8'hAB); tick();
    drive(0, 6'b000000, 1, 8'h1E, 8'h55); tick();
    drive(0, 6'b000000, 1, 8'h2F, 8'h77); tick();
    drive(0, 6'b000000, 1, 8'h30, 8'h11); tick();
    drive(0, 6'b000000, 1, 8'h01, 8'h3F); tick();
    #1 chk("ill.busy", int'(busy), 0);
    for (int k = 0; k < 6; k++) rot(k);
    drive(1, 6'b000000, 0, 8'h00, 8'h00); tick();
    drive(1, 6'b000011, 0, 8'h00, 8'h00); tick();

    // Reset mid-rotation drops everything pending.
    drive(0, 6'b000000, 1, 8'h00, 8'h3F); tick();
    drive(0, 6'b000000, 1, 8'h1A, 8'h99); tick();
    rot(0); rot(1);
    @(negedge clk);
    cen = 1'b1; cur_ch = 6'b000100; wr = 1'b0; rst = 1'b1;
    #1;
    chk("rst.aon", int'(aon), 0);
    chk("rst.aoff", int'(aoff), 0);
    chk("rst.up_start", int'(up_start), 0);
    chk("rst.addr_in", int'(addr_in), 0);
    chk("rst.addr_ch", int'(addr_ch), 0);
    chk("rst.en_ch", int'(en_ch), 0);
    chk("rst.busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 2; r++) for (int k = 0; k < 6; k++) rot(k);

    // Random traffic against the model.
    begin
      int pos;
      logic [5:0] cc;
      logic [7:0] a;
      pos = 0;
      for (int n = 0; n < 3000; n++) begin
        case ($urandom_range(0, 9))
          0, 1:    a = 8'h00;
          2, 3:    a = 8'(8'h10 + $urandom_range(0, 7));
          4, 5:    a = 8'(8'h18 + $urandom_range(0, 7));
          6:       a = 8'(8'h20 + $urandom_range(0, 7));
          7, 8:    a = 8'(8'h28 + $urandom_range(0, 7));
          default: a = 8'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 15))
          0:       cc = 6'd0;
          1:       cc = 6'($urandom_range(0, 63));
          default: cc = 6'(1 << pos);
        endcase
        drive(($urandom_range(0, 2) == 0), cc, ($urandom_range(0, 3) == 0), a,
              8'($urandom_range(0, 255)));
        if (cen) pos = (pos + 1) % 6;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
